// File: rtl/imem_ctrl.sv
// imem_ctrl - synchronous-read instruction memory sitting between the fetch
// stage and instruction storage. Requests and responses use valid/ready
// handshakes, a fixed number of wait states can be inserted before each
// response, and a program-load port writes the array while the core is held.
//
// Optional feature macro: IMEM_ADDR_CHECK_EN
//   defined   : misaligned or out-of-window addresses are flagged. Errored
//               reads return a NOP with op_inst_err = 1, errored loads are
//               dropped.
//   undefined : op_inst_err stays 0, and addresses wrap onto the word index
//               field (high bits and byte-offset bits are ignored).

module imem_ctrl #(
    parameter int unsigned SIZE_IN_WORDS = 1024,
    parameter int unsigned WAIT_STATES   = 0,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000
) (
    input  logic        ip_clk,
    input  logic        ip_rst_n,
    input  logic        ip_req_valid,
    output logic        op_req_ready,
    input  logic [31:0] ip_inst_addr,
    output logic        op_inst_valid,
    input  logic        ip_inst_ready,
    output logic [31:0] op_inst_from_imem,
    output logic        op_inst_err,
    input  logic        ip_load_en,
    input  logic [31:0] ip_load_addr,
    input  logic [31:0] ip_load_data,
    output logic        op_busy
);

    localparam int unsigned IDX_W    = $clog2(SIZE_IN_WORDS);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);
    // With no wait states the accept edge is also the capture edge.
    localparam bit          NO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte address -> word index relative to the mapped window. Bits above
    // the index field fall away, which gives the wrap-around behaviour.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] offs;
        offs = addr - BASE_ADDR;
        return IDX_W'(offs >> 2);
    endfunction

`ifdef IMEM_ADDR_CHECK_EN
    localparam logic [32:0] SPAN_BYTES = 33'(SIZE_IN_WORDS) << 2;

    // An address is bad when misaligned, below the window, or past its end.
    // The 33-bit difference carries a borrow for addresses below BASE_ADDR.
    function automatic logic addr_bad(input logic [31:0] addr);
        logic [32:0] offs;
        offs = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (addr[1:0] != 2'b00) || offs[32] || (offs >= SPAN_BYTES);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] mem [SIZE_IN_WORDS];
    logic [31:0] rd_word_q;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;             // latched request index
    logic             req_err_q, req_err_d;     // latched request error
    logic             resp_err_q, resp_err_d;   // error of the held response
    logic             resp_loaded_q, resp_loaded_d;

    logic             accept;
    logic             capture;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_err;

    logic [IDX_W-1:0] new_idx;
    logic             new_err;
    logic [IDX_W-1:0] load_idx;
    logic             load_err;
    logic             load_we;

    assign new_idx  = word_idx(ip_inst_addr);
    assign load_idx = word_idx(ip_load_addr);

`ifdef IMEM_ADDR_CHECK_EN
    assign new_err  = addr_bad(ip_inst_addr);
    assign load_err = addr_bad(ip_load_addr);
`else
    assign new_err  = 1'b0;
    assign load_err = 1'b0;
`endif

    assign load_we = ip_load_en && !load_err;

    // Next-state, handshake and capture decode for the request/response FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        req_err_d     = req_err_q;
        resp_err_d    = resp_err_q;
        resp_loaded_d = resp_loaded_q;
        capture       = 1'b0;
        cap_idx       = idx_q;
        cap_err       = req_err_q;
        op_req_ready  = 1'b0;

        // Ready never looks at ip_req_valid, so there is no loop through
        // the requester.
        case (state_q)
            ST_IDLE: op_req_ready = 1'b1;
            ST_WAIT: op_req_ready = 1'b0;
            ST_RESP: op_req_ready = ip_inst_ready;
            default: op_req_ready = 1'b0;
        endcase

        accept = op_req_ready && ip_req_valid;

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end
            end
            ST_RESP: begin
                // Consumed: fall back to idle unless a new request is
                // accepted in the same cycle (handled below).
                if (ip_inst_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // A new accept looks identical whether it came from IDLE or from a
        // consumed response.
        if (accept) begin
            idx_d     = new_idx;
            req_err_d = new_err;
            if (NO_WAIT) begin
                state_d = ST_RESP;
                capture = 1'b1;
                cap_idx = new_idx;
                cap_err = new_err;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_CNT;
            end
        end

        if (capture) begin
            resp_err_d    = cap_err;
            resp_loaded_d = 1'b1;
        end
    end

    // State and holding registers; reset drops any request or response.
    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            idx_q         <= '0;
            req_err_q     <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_loaded_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            req_err_q     <= req_err_d;
            resp_err_q    <= resp_err_d;
            resp_loaded_q <= resp_loaded_d;
        end
    end

    // Program-load write port; contents are never reset.
    always_ff @(posedge ip_clk) begin
        if (load_we) begin
            mem[load_idx] <= ip_load_data;
        end
    end

    // Registered read on the edge that enters RESP. A load to the same
    // index on that edge lands after the read, so the response sees the
    // old word.
    always_ff @(posedge ip_clk) begin
        if (capture) begin
            rd_word_q <= mem[cap_idx];
        end
    end

    // The read register carries no reset, so the output is forced to zero
    // until the first response has been captured after reset.
    assign op_inst_from_imem = !resp_loaded_q ? 32'h0000_0000 :
                               resp_err_q     ? NOP_INSN      : rd_word_q;
    assign op_inst_err       = resp_err_q;
    assign op_inst_valid     = (state_q == ST_RESP);
    assign op_busy           = (state_q != ST_IDLE);

endmodule
